// File: rtl/nibble_serial_comparator.sv
// Serial magnitude comparator: compares A and B one nibble per cycle, MSB first,
// and falls back to the cascade inputs when every nibble matches.
module nibble_serial_comparator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             e,
  input  logic             l,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             E,
  output logic             L,
  output logic             G
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic             eReg;
  logic             lReg;
  logic             gReg;
  logic             decided;
  logic             gtRec;
  logic [IW-1:0]    idx;

  logic [3:0]       aNib;
  logic [3:0]       bNib;
  logic             decNext;
  logic             gtNext;

  // Operands shift left each CMP cycle, so the nibble under test is always on top.
  // Once decided, the recorded direction is frozen.
  always_comb begin
    aNib    = aReg[WIDTH-1 -: 4];
    bNib    = bReg[WIDTH-1 -: 4];
    decNext = decided | (aNib != bNib);
    gtNext  = decided ? gtRec : (aNib > bNib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aReg    <= '0;
      bReg    <= '0;
      eReg    <= 1'b0;
      lReg    <= 1'b0;
      gReg    <= 1'b0;
      decided <= 1'b0;
      gtRec   <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      E       <= 1'b0;
      L       <= 1'b0;
      G       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            aReg    <= a;
            bReg    <= b;
            eReg    <= e;
            lReg    <= l;
            gReg    <= g;
            decided <= 1'b0;
            gtRec   <= 1'b0;
            idx     <= IW'(N - 1);
            busy    <= 1'b1;
            state   <= CMP;
          end
        end
        CMP: begin
          decided <= decNext;
          gtRec   <= gtNext;
          aReg    <= aReg << 4;
          bReg    <= bReg << 4;
          if (idx == '0) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            // The last nibble's outcome is folded in here via decNext/gtNext.
            if (decNext) begin
              E <= 1'b0;
              L <= ~gtNext;
              G <= gtNext;
            end else if (eReg) begin
              E <= 1'b1;
              L <= 1'b0;
              G <= 1'b0;
            end else begin
              E <= 1'b0;
              L <= lReg;
              G <= gReg;
            end
          end else begin
            idx <= idx - 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_comparator.sv
// Self-checking bench for nibble_serial_comparator (WIDTH=16): vector table,
// expected-result queue, and hand-written sequences for abort/ignore/back-to-back cases.
module tb_nibble_serial_comparator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        e;
  logic        l;
  logic        g;
  logic        busy;
  logic        done;
  logic        E;
  logic        L;
  logic        G;

  int compared = 0;
  int mismatched = 0;

  logic [2:0] expQ[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        e;
    logic        l;
    logic        g;
    logic [2:0]  exp;
  } vec_t;

  vec_t vecs[10];

  nibble_serial_comparator #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .e(e), .l(l), .g(g),
    .busy(busy), .done(done), .E(E), .L(L), .G(G)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one start pulse at a falling edge and records the expected {E,L,G}.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic ev, input logic lv, input logic gv,
                               input logic [2:0] exp);
    a = av; b = bv; e = ev; l = lv; g = gv;
    start = 1'b1;
    expQ.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic popAndCompare(input string name);
    logic [2:0] exp;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: done with empty queue, got %0h, expected none", name, {E, L, G});
    end else begin
      exp = expQ.pop_front();
      checkOutput({name, " ELG"}, {29'd0, E, L, G}, {29'd0, exp});
    end
  endtask

  // Called one cycle after the accepting edge; done must appear at cycle 5.
  task automatic waitDone(input string name);
    int cycles = 1;
    int busyCnt = 0;
    bit seen = 0;
    while (!seen && cycles <= 20) begin
      if (busy) busyCnt++;
      if (done) seen = 1;
      else begin
        @(negedge clk);
        cycles++;
      end
    end
    checkOutput({name, " done seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      checkOutput({name, " latency"}, cycles, 32'd5);
      checkOutput({name, " busy cycles"}, busyCnt, 32'd4);
      popAndCompare(name);
      @(negedge clk);
      checkOutput({name, " done pulse"}, {30'd0, done, busy}, 32'd0);
    end
  endtask

  task automatic expectNoDone(input string name, input int cyclesToWatch);
    int seenCnt = 0;
    for (int i = 0; i < cyclesToWatch; i++) begin
      if (done) seenCnt++;
      @(negedge clk);
    end
    checkOutput({name, " no done"}, seenCnt, 32'd0);
  endtask

  initial begin
    int doneCnt;
    int lastDone;
    int badGap;

    vecs[0] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 3'b100};
    vecs[1] = '{16'hF000, 16'h0FFF, 1'b0, 1'b0, 1'b0, 3'b001};
    vecs[2] = '{16'h000E, 16'h000F, 1'b0, 1'b0, 1'b0, 3'b010};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 3'b011};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[5] = '{16'h5678, 16'h5678, 1'b1, 1'b1, 1'b1, 3'b100};
    vecs[6] = '{16'h1235, 16'h1234, 1'b0, 1'b1, 1'b0, 3'b001};
    vecs[7] = '{16'h0F00, 16'h1000, 1'b0, 1'b0, 1'b1, 3'b010};
    vecs[8] = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0, 3'b010};
    vecs[9] = '{16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1, 3'b001};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; e = 1'b0; l = 1'b0; g = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset outputs", {27'd0, busy, done, E, L, G}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].l, vecs[i].g, vecs[i].exp);
      waitDone($sformatf("vec%0d", i));
    end

    // In-flight operand changes and start pulses in CMP/FIN must be ignored.
    applyStimulus(16'h1000, 16'h2000, 1'b0, 1'b0, 1'b1, 3'b010);
    a = 16'hFFFF; b = 16'h0000; e = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("inflight done", {31'd0, done}, 32'd1);
    popAndCompare("inflight");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expectNoDone("ignored start", 10);
    checkOutput("ignored start idle", {31'd0, busy}, 32'd0);

    // Reset in the second CMP cycle aborts with no done pulse.
    a = 16'h8000; b = 16'h0001; e = 1'b0; l = 1'b0; g = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort outputs", {27'd0, busy, done, E, L, G}, 32'd0);
    expectNoDone("abort", 8);
    applyStimulus(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b001);
    waitDone("after abort");

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checkOutput("rst over start busy", {31'd0, busy}, 32'd0);
    expectNoDone("rst over start", 8);

    // Start held high for 20 edges: accepts at 0, 6, 12, 18 -> done at cycles 5, 11, 17, 23.
    a = 16'h0002; b = 16'h0001; e = 1'b0; l = 1'b0; g = 1'b0;
    for (int k = 0; k < 4; k++) expQ.push_back(3'b001);
    start = 1'b1;
    doneCnt = 0; lastDone = -1; badGap = 0;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (t == 20) start = 1'b0;
      if (done) begin
        if (lastDone < 0) begin
          if (t != 5) badGap++;
        end else if (t - lastDone != 6) begin
          badGap++;
        end
        lastDone = t;
        doneCnt++;
        popAndCompare($sformatf("held start %0d", doneCnt));
      end
    end
    checkOutput("held start done count", doneCnt, 32'd4);
    checkOutput("held start spacing", badGap, 32'd0);
    checkOutput("queue drained", expQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
